// File: rtl/iso_rx_unsteer.sv
// Isochronous receive path: decodes BS/SR/BE/FS/FE framing, captures VB-ID,
// drops transfer-unit stuffing and re-assembles 8bpc RGB pixels from 1/2/4 lanes.
module iso_rx_unsteer #(
   parameter logic [7:0] K_BS = 8'hBC,
   parameter logic [7:0] K_SR = 8'h1C,
   parameter logic [7:0] K_BE = 8'hFB,
   parameter logic [7:0] K_FS = 8'hFE,
   parameter logic [7:0] K_FE = 8'hF7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_en,
   input  logic [1:0]  td_lane_count,
   input  logic [7:0]  rx_symbols_lane0,
   input  logic [7:0]  rx_symbols_lane1,
   input  logic [7:0]  rx_symbols_lane2,
   input  logic [7:0]  rx_symbols_lane3,
   input  logic        rx_control_sym_flag_lane0,
   input  logic        rx_control_sym_flag_lane1,
   input  logic        rx_control_sym_flag_lane2,
   input  logic        rx_control_sym_flag_lane3,
   output logic [95:0] rx_pixel_data,
   output logic        rx_pixel_vld,
   output logic [2:0]  rx_pixel_num,
   output logic [7:0]  rx_vbid,
   output logic        rx_vbid_vld,
   output logic        rx_vblank,
   output logic        rx_line_start,
   output logic        rx_line_end,
   output logic        rx_err_align,
   output logic        rx_err_partial
);

   typedef enum logic [2:0] {
      IDLE,
      HUNT,
      BLANK_HDR,
      BLANK,
      ACTIVE,
      STUFF
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       lanes_q, lanes_d;
   logic [3:0]       hdrCnt_q, hdrCnt_d;
   logic [1:0]       byteIdx_q, byteIdx_d;
   logic [3:0][7:0]  rByte_q, rByte_d;
   logic [3:0][7:0]  gByte_q, gByte_d;
   logic [95:0]      pixData_q, pixData_d;
   logic [2:0]       pixNum_q, pixNum_d;
   logic             pixVld_q, pixVld_d;
   logic [7:0]       vbid_q, vbid_d;
   logic             vbidVld_q, vbidVld_d;
   logic             lineStart_q, lineStart_d;
   logic             lineEnd_q, lineEnd_d;
   logic             errAlign_q, errAlign_d;
   logic             errPartial_q, errPartial_d;

   logic [3:0][7:0]  sym;
   logic [3:0]       flg;
   logic [2:0]       laneCfg;
   logic [2:0]       lanesEff;
   logic [3:0]       laneMask;
   logic [3:0]       hdrLoad;
   logic             alignErr;
   logic             isCtl;
   logic             isBS;
   logic             isBE;
   logic             isFS;
   logic             isFE;

   assign sym = {rx_symbols_lane3, rx_symbols_lane2, rx_symbols_lane1, rx_symbols_lane0};
   assign flg = {rx_control_sym_flag_lane3, rx_control_sym_flag_lane2,
                 rx_control_sym_flag_lane1, rx_control_sym_flag_lane0};

   always_comb begin
      case (td_lane_count)
         2'b01:   laneCfg = 3'd2;
         2'b11:   laneCfg = 3'd4;
         default: laneCfg = 3'd1;
      endcase
   end

   // Lane count follows the input only while hunting; it is frozen once framing is found.
   assign lanesEff = (state_q == IDLE || state_q == HUNT) ? laneCfg : lanes_q;

   always_comb begin
      case (lanesEff)
         3'd4: begin
            laneMask = 4'b1111;
            hdrLoad  = 4'd3;
         end
         3'd2: begin
            laneMask = 4'b0011;
            hdrLoad  = 4'd6;
         end
         default: begin
            laneMask = 4'b0001;
            hdrLoad  = 4'd12;
         end
      endcase
   end

   always_comb begin
      alignErr = 1'b0;
      for (int l = 1; l < 4; l++) begin
         if (laneMask[l]) begin
            if (flg[l] != flg[0]) begin
               alignErr = 1'b1;
            end else if (flg[0] && (sym[l] != sym[0])) begin
               alignErr = 1'b1;
            end
         end
      end
   end

   assign isCtl = flg[0];
   assign isBS  = isCtl && ((sym[0] == K_BS) || (sym[0] == K_SR));
   assign isBE  = isCtl && (sym[0] == K_BE);
   assign isFS  = isCtl && (sym[0] == K_FS);
   assign isFE  = isCtl && (sym[0] == K_FE);

   // Next-state and output decode; a misaligned cycle only raises the error pulse.
   always_comb begin
      state_d      = state_q;
      lanes_d      = lanesEff;
      hdrCnt_d     = hdrCnt_q;
      byteIdx_d    = byteIdx_q;
      rByte_d      = rByte_q;
      gByte_d      = gByte_q;
      pixData_d    = pixData_q;
      pixNum_d     = pixNum_q;
      pixVld_d     = 1'b0;
      vbid_d       = vbid_q;
      vbidVld_d    = 1'b0;
      lineStart_d  = 1'b0;
      lineEnd_d    = 1'b0;
      errAlign_d   = 1'b0;
      errPartial_d = 1'b0;

      if (!rx_en) begin
         state_d   = IDLE;
         hdrCnt_d  = 4'd0;
         byteIdx_d = 2'd0;
      end else if (alignErr) begin
         errAlign_d = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = HUNT;
            end
            HUNT: begin
               if (isBS) begin
                  state_d  = BLANK_HDR;
                  hdrCnt_d = hdrLoad;
               end
            end
            BLANK_HDR: begin
               if (isCtl) begin
                  state_d  = HUNT;
                  hdrCnt_d = 4'd0;
               end else begin
                  if (hdrCnt_q == hdrLoad) begin
                     vbid_d    = sym[0];
                     vbidVld_d = 1'b1;
                  end
                  if (hdrCnt_q != 4'd0) begin
                     hdrCnt_d = hdrCnt_q - 4'd1;
                  end
                  if (hdrCnt_q <= 4'd1) begin
                     state_d = BLANK;
                  end
               end
            end
            BLANK: begin
               if (isBE) begin
                  state_d     = ACTIVE;
                  lineStart_d = 1'b1;
                  byteIdx_d   = 2'd0;
               end else if (isBS) begin
                  state_d  = BLANK_HDR;
                  hdrCnt_d = hdrLoad;
               end
            end
            ACTIVE, STUFF: begin
               if (isBS) begin
                  state_d      = BLANK_HDR;
                  hdrCnt_d     = hdrLoad;
                  lineEnd_d    = 1'b1;
                  errPartial_d = (byteIdx_q != 2'd0);
                  byteIdx_d    = 2'd0;
               end else if (state_q == STUFF) begin
                  if (isFE) begin
                     state_d = ACTIVE;
                  end
               end else if (isFS) begin
                  state_d = STUFF;
               end else if (!isCtl) begin
                  case (byteIdx_q)
                     2'd0: begin
                        rByte_d   = sym;
                        byteIdx_d = 2'd1;
                     end
                     2'd1: begin
                        gByte_d   = sym;
                        byteIdx_d = 2'd2;
                     end
                     default: begin
                        byteIdx_d = 2'd0;
                        pixVld_d  = 1'b1;
                        pixNum_d  = lanesEff;
                        for (int l = 0; l < 4; l++) begin
                           pixData_d[24*l +: 24] = laneMask[l] ? {rByte_q[l], gByte_q[l], sym[l]} : 24'h0;
                        end
                     end
                  endcase
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         lanes_q      <= 3'd1;
         hdrCnt_q     <= 4'd0;
         byteIdx_q    <= 2'd0;
         rByte_q      <= '0;
         gByte_q      <= '0;
         pixData_q    <= '0;
         pixNum_q     <= 3'd0;
         pixVld_q     <= 1'b0;
         vbid_q       <= 8'h00;
         vbidVld_q    <= 1'b0;
         lineStart_q  <= 1'b0;
         lineEnd_q    <= 1'b0;
         errAlign_q   <= 1'b0;
         errPartial_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lanes_q      <= lanes_d;
         hdrCnt_q     <= hdrCnt_d;
         byteIdx_q    <= byteIdx_d;
         rByte_q      <= rByte_d;
         gByte_q      <= gByte_d;
         pixData_q    <= pixData_d;
         pixNum_q     <= pixNum_d;
         pixVld_q     <= pixVld_d;
         vbid_q       <= vbid_d;
         vbidVld_q    <= vbidVld_d;
         lineStart_q  <= lineStart_d;
         lineEnd_q    <= lineEnd_d;
         errAlign_q   <= errAlign_d;
         errPartial_q <= errPartial_d;
      end
   end

   assign rx_pixel_data  = pixData_q;
   assign rx_pixel_vld   = pixVld_q;
   assign rx_pixel_num   = pixNum_q;
   assign rx_vbid        = vbid_q;
   assign rx_vbid_vld    = vbidVld_q;
   assign rx_vblank      = vbid_q[0];
   assign rx_line_start  = lineStart_q;
   assign rx_line_end    = lineEnd_q;
   assign rx_err_align   = errAlign_q;
   assign rx_err_partial = errPartial_q;

endmodule

// File: tb/tb_iso_rx_unsteer.sv
// Testbench for iso_rx_unsteer: a table of per-cycle symbol vectors with the expected
// registered outputs, replayed through a scoreboard queue one cycle behind the stimulus.
module tb_iso_rx_unsteer;

   localparam logic [7:0] K_BS = 8'hBC;
   localparam logic [7:0] K_SR = 8'h1C;
   localparam logic [7:0] K_BE = 8'hFB;
   localparam logic [7:0] K_FS = 8'hFE;
   localparam logic [7:0] K_FE = 8'hF7;

   localparam logic [5:0] P_NONE = 6'b000000;
   localparam logic [5:0] P_VLD  = 6'b100000;
   localparam logic [5:0] P_VB   = 6'b010000;
   localparam logic [5:0] P_LS   = 6'b001000;
   localparam logic [5:0] P_LE   = 6'b000100;
   localparam logic [5:0] P_EA   = 6'b000010;
   localparam logic [5:0] P_EP   = 6'b000001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_en;
   logic [1:0]  td_lane_count;
   logic [7:0]  rx_symbols_lane0, rx_symbols_lane1, rx_symbols_lane2, rx_symbols_lane3;
   logic        rx_control_sym_flag_lane0, rx_control_sym_flag_lane1;
   logic        rx_control_sym_flag_lane2, rx_control_sym_flag_lane3;
   logic [95:0] rx_pixel_data;
   logic        rx_pixel_vld;
   logic [2:0]  rx_pixel_num;
   logic [7:0]  rx_vbid;
   logic        rx_vbid_vld;
   logic        rx_vblank;
   logic        rx_line_start;
   logic        rx_line_end;
   logic        rx_err_align;
   logic        rx_err_partial;

   typedef struct {
      string       name;
      logic        en;
      logic [1:0]  lc;
      logic [3:0]  flg;
      logic [31:0] sym;
      logic        vld;
      logic [2:0]  num;
      logic [95:0] pix;
      logic [7:0]  vbid;
      logic        vbidVld;
      logic        ls;
      logic        le;
      logic        ea;
      logic        ep;
   } vec_t;

   vec_t        vecs[$];
   vec_t        sbq[$];
   logic [7:0]  curVbid;
   logic [95:0] curPix;
   int          testsRun = 0;
   int          testsFailed = 0;

   iso_rx_unsteer dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .rx_en                     (rx_en),
      .td_lane_count             (td_lane_count),
      .rx_symbols_lane0          (rx_symbols_lane0),
      .rx_symbols_lane1          (rx_symbols_lane1),
      .rx_symbols_lane2          (rx_symbols_lane2),
      .rx_symbols_lane3          (rx_symbols_lane3),
      .rx_control_sym_flag_lane0 (rx_control_sym_flag_lane0),
      .rx_control_sym_flag_lane1 (rx_control_sym_flag_lane1),
      .rx_control_sym_flag_lane2 (rx_control_sym_flag_lane2),
      .rx_control_sym_flag_lane3 (rx_control_sym_flag_lane3),
      .rx_pixel_data             (rx_pixel_data),
      .rx_pixel_vld              (rx_pixel_vld),
      .rx_pixel_num              (rx_pixel_num),
      .rx_vbid                   (rx_vbid),
      .rx_vbid_vld               (rx_vbid_vld),
      .rx_vblank                 (rx_vblank),
      .rx_line_start             (rx_line_start),
      .rx_line_end               (rx_line_end),
      .rx_err_align              (rx_err_align),
      .rx_err_partial            (rx_err_partial)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [31:0] ctl4(input logic [7:0] code);
      return {code, code, code, code};
   endfunction

   // Records one cycle of stimulus together with the outputs expected one cycle later.
   task automatic addVec(input string name, input logic en, input logic [1:0] lc,
                         input logic [3:0] flg, input logic [31:0] sym, input logic [5:0] p,
                         input logic [2:0] num = 3'd0, input logic [95:0] pixNew = '0,
                         input logic [7:0] vbidNew = 8'h00);
      vec_t v;
      if (p[4]) curVbid = vbidNew;
      if (p[5]) curPix = pixNew;
      v.name    = name;
      v.en      = en;
      v.lc      = lc;
      v.flg     = flg;
      v.sym     = sym;
      v.vld     = p[5];
      v.vbidVld = p[4];
      v.ls      = p[3];
      v.le      = p[2];
      v.ea      = p[1];
      v.ep      = p[0];
      v.num     = num;
      v.pix     = curPix;
      v.vbid    = curVbid;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      rx_en                     = v.en;
      td_lane_count             = v.lc;
      rx_symbols_lane0          = v.sym[7:0];
      rx_symbols_lane1          = v.sym[15:8];
      rx_symbols_lane2          = v.sym[23:16];
      rx_symbols_lane3          = v.sym[31:24];
      rx_control_sym_flag_lane0 = v.flg[0];
      rx_control_sym_flag_lane1 = v.flg[1];
      rx_control_sym_flag_lane2 = v.flg[2];
      rx_control_sym_flag_lane3 = v.flg[3];
   endtask

   task automatic checkOutput(input vec_t e);
      logic ok;
      testsRun++;
      ok = (rx_pixel_vld === e.vld) && (rx_pixel_data === e.pix) && (rx_vbid === e.vbid) &&
           (rx_vblank === e.vbid[0]) && (rx_vbid_vld === e.vbidVld) &&
           (rx_line_start === e.ls) && (rx_line_end === e.le) &&
           (rx_err_align === e.ea) && (rx_err_partial === e.ep) &&
           (!e.vld || (rx_pixel_num === e.num));
      if (!ok) begin
         testsFailed++;
         $display("[TB] FAIL %s: got vld=%0b num=%0d pix=%h vbid=%h vv=%0b vbl=%0b ls=%0b le=%0b ea=%0b ep=%0b, want vld=%0b num=%0d pix=%h vbid=%h vv=%0b vbl=%0b ls=%0b le=%0b ea=%0b ep=%0b",
                  e.name, rx_pixel_vld, rx_pixel_num, rx_pixel_data, rx_vbid, rx_vbid_vld,
                  rx_vblank, rx_line_start, rx_line_end, rx_err_align, rx_err_partial,
                  e.vld, e.num, e.pix, e.vbid, e.vbidVld, e.vbid[0], e.ls, e.le, e.ea, e.ep);
      end
   endtask

   task automatic checkAllZero(input string name);
      logic [117:0] act;
      act = {rx_pixel_data, rx_pixel_vld, rx_pixel_num, rx_vbid, rx_vbid_vld, rx_vblank,
             rx_line_start, rx_line_end, rx_err_align, rx_err_partial};
      testsRun++;
      if (act !== '0) begin
         testsFailed++;
         $display("[TB] FAIL %s: outputs got %h, want all zero", name, act);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (sbq.size() > 0) begin
         checkOutput(sbq.pop_front());
      end
   end

   initial begin
      curVbid = 8'h00;
      curPix  = '0;

      // 4 lanes: header with VB-ID 01, one pixel, then misalignment while in BLANK.
      addVec("a_idle_to_hunt", 1, 2'b11, 4'h0, 32'h0, P_NONE);
      addVec("a_hunt_data",    1, 2'b11, 4'h0, 32'h0, P_NONE);
      addVec("a_bs",           1, 2'b11, 4'hF, ctl4(K_BS), P_NONE);
      addVec("a_vbid",         1, 2'b11, 4'h0, 32'h01010101, P_VB, 3'd0, '0, 8'h01);
      addVec("a_hdr1",         1, 2'b11, 4'h0, 32'h99999999, P_NONE);
      addVec("a_hdr2",         1, 2'b11, 4'h0, 32'h88888888, P_NONE);
      addVec("a_be",           1, 2'b11, 4'hF, ctl4(K_BE), P_LS);
      addVec("a_r",            1, 2'b11, 4'h0, 32'h0D0C0B0A, P_NONE);
      addVec("a_g",            1, 2'b11, 4'h0, 32'h17161514, P_NONE);
      addVec("a_b_pixel",      1, 2'b11, 4'h0, 32'h21201F1E, P_VLD, 3'd4,
             {24'h0D1721, 24'h0C1620, 24'h0B151F, 24'h0A141E});
      addVec("a_bs_line_end",  1, 2'b11, 4'hF, ctl4(K_BS), P_LE);
      addVec("a_vbid0",        1, 2'b11, 4'h0, 32'h00000000, P_VB, 3'd0, '0, 8'h00);
      addVec("a_hdr3",         1, 2'b11, 4'h0, 32'h77777777, P_NONE);
      addVec("a_hdr4",         1, 2'b11, 4'h0, 32'h66666666, P_NONE);
      addVec("a_flag_mis",     1, 2'b11, 4'b1011, {K_BE, 8'h00, K_BE, K_BE}, P_EA);
      addVec("a_code_mis",     1, 2'b11, 4'hF, {K_BE, K_BE, K_BS, K_BE}, P_EA);
      addVec("a_be_aligned",   1, 2'b11, 4'hF, ctl4(K_BE), P_LS);
      addVec("a_r2",           1, 2'b11, 4'h0, 32'h33323130, P_NONE);
      addVec("a_g2",           1, 2'b11, 4'h0, 32'h43424140, P_NONE);
      addVec("a_sr_partial",   1, 2'b11, 4'hF, ctl4(K_SR), P_LE | P_EP);
      addVec("a_vbid5",        1, 2'b11, 4'h0, 32'h05050505, P_VB, 3'd0, '0, 8'h05);
      addVec("a_hdr5",         1, 2'b11, 4'h0, 32'h11111111, P_NONE);
      addVec("a_hdr6",         1, 2'b11, 4'h0, 32'h22222222, P_NONE);
      addVec("a_be3",          1, 2'b11, 4'hF, ctl4(K_BE), P_LS);
      addVec("a_r3",           1, 2'b11, 4'h0, 32'h5A5A5A5A, P_NONE);
      // rx_en drop mid-pixel, then re-enable with a single lane.
      addVec("en_low",         0, 2'b00, 4'h0, 32'h6B6B6B6B, P_NONE);
      addVec("en_low_bs",      0, 2'b00, 4'hF, ctl4(K_BS), P_NONE);
      addVec("b_reenable",     1, 2'b00, 4'h0, 32'h0, P_NONE);
      addVec("b_bs",           1, 2'b00, 4'b0001, {24'hC3C3C3, K_BS}, P_NONE);
      addVec("b_vbid",         1, 2'b00, 4'b1000, 32'hFFEE1102, P_VB, 3'd0, '0, 8'h02);
      for (int i = 0; i < 11; i++) begin
         addVec("b_hdr", 1, 2'b00, 4'b0110, 32'h12345670 + i, P_NONE);
      end
      addVec("b_be",           1, 2'b00, 4'b1111, {24'h1C1CBC, K_BE}, P_LS);
      addVec("b_r1",           1, 2'b00, 4'h0, 32'hAABBCC40, P_NONE);
      addVec("b_g1",           1, 2'b00, 4'b1110, 32'hFBFBFB41, P_NONE);
      addVec("b_b1",           1, 2'b00, 4'h0, 32'h00000042, P_VLD, 3'd1, {72'h0, 24'h404142});
      addVec("b_r2",           1, 2'b00, 4'h0, 32'h11111150, P_NONE);
      addVec("b_g2",           1, 2'b00, 4'h0, 32'h22222251, P_NONE);
      addVec("b_b2",           1, 2'b00, 4'h0, 32'h33333352, P_VLD, 3'd1, {72'h0, 24'h505152});
      addVec("b_bs_line_end",  1, 2'b00, 4'hF, ctl4(K_BS), P_LE);
      // 2 lanes: stuffing between G and B bytes.
      addVec("c_en_low",       0, 2'b01, 4'h0, 32'h0, P_NONE);
      addVec("c_reenable",     1, 2'b01, 4'h0, 32'h0, P_NONE);
      addVec("c_bs",           1, 2'b01, 4'b1011, {8'hEE, 8'h00, K_BS, K_BS}, P_NONE);
      addVec("c_vbid",         1, 2'b01, 4'b0100, 32'hEEEE0303, P_VB, 3'd0, '0, 8'h03);
      for (int i = 0; i < 5; i++) begin
         addVec("c_hdr", 1, 2'b01, 4'b0100, 32'hABCD0000 + i, P_NONE);
      end
      addVec("c_be",           1, 2'b01, 4'b1011, {8'hEE, 8'h00, K_BE, K_BE}, P_LS);
      addVec("c_r",            1, 2'b01, 4'b0100, 32'hEEEE7161, P_NONE);
      addVec("c_g",            1, 2'b01, 4'b0100, 32'hEEEE7262, P_NONE);
      addVec("c_fs",           1, 2'b01, 4'b1011, {8'hEE, 8'h00, K_FS, K_FS}, P_NONE);
      addVec("c_stuff1",       1, 2'b01, 4'h0, 32'hAAAAAAAA, P_NONE);
      addVec("c_stuff2",       1, 2'b01, 4'h0, 32'hBBBBBBBB, P_NONE);
      addVec("c_stuff3",       1, 2'b01, 4'h0, 32'hCCCCCCCC, P_NONE);
      addVec("c_fe",           1, 2'b01, 4'b0011, {16'h0000, K_FE, K_FE}, P_NONE);
      addVec("c_b_pixel",      1, 2'b01, 4'b0100, 32'hEEEE7363, P_VLD, 3'd2,
             {48'h0, 24'h717273, 24'h616263});
      addVec("c_be_ignored",   1, 2'b01, 4'b0011, {16'h0000, K_BE, K_BE}, P_NONE);
      addVec("c_fs2",          1, 2'b01, 4'b0011, {16'h0000, K_FS, K_FS}, P_NONE);
      addVec("c_sr_in_stuff",  1, 2'b01, 4'b0011, {16'h0000, K_SR, K_SR}, P_LE);

      rst_n = 1'b0;
      applyStimulus('{name: "init", en: 1'b0, lc: 2'b00, flg: 4'h0, sym: 32'h0, vld: 1'b0,
                      num: 3'd0, pix: '0, vbid: 8'h00, vbidVld: 1'b0, ls: 1'b0, le: 1'b0,
                      ea: 1'b0, ep: 1'b0});
      #12;
      checkAllZero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         sbq.push_back(vecs[i]);
      end
      @(negedge clk);
      rx_en = 1'b0;
      for (int i = 0; i < 5 && sbq.size() != 0; i++) begin
         @(negedge clk);
      end
      testsRun++;
      if (sbq.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
      end

      // Asynchronous reset away from any clock edge must clear held VB-ID and pixel data.
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("async_reset");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/iso_rx_unsteer.md
Name: iso_rx_unsteer

Overview:
- Sink-side counterpart of the isochronous transmit path: consumes per-lane 8-bit symbols plus control flags and recovers video timing and 8bpc RGB pixels.
- Decodes framing symbols BS/SR/BE/FS/FE, captures VB-ID, strips transfer-unit stuffing and un-steers pixel bytes from 1/2/4 lanes.
- Runs on the link-symbol clock.
- Used as loopback checker and sink model for the transmit path.

Parameters:
- K_BS, 8'hBC, blanking-start code (K28.5)
- K_SR, 8'h1C, scrambler-reset code (K28.0); treated as BS
- K_BE, 8'hFB, blanking-end code (K27.7)
- K_FS, 8'hFE, fill-start code (K30.7)
- K_FE, 8'hF7, fill-end code (K23.7)

Ports:
- clk  in  1  link symbol clock; one clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- rx_en  in  1  decoder enable; low forces IDLE
- td_lane_count  in  2  00=1 lane, 01=2 lanes, 11=4 lanes, 10 treated as 1 lane; sampled only in IDLE/HUNT
- rx_symbols_lane0..3  in  8 each  lane symbols
- rx_control_sym_flag_lane0..3  in  1 each  1 = symbol is a control code
- rx_pixel_data  out  96  slot L = bits[24L+23:24L] = {R,G,B} from lane L
- rx_pixel_vld  out  1  pixel group valid, 1-cycle pulse
- rx_pixel_num  out  3  valid slots in group (1/2/4)
- rx_vbid  out  8  last captured VB-ID
- rx_vbid_vld  out  1  pulse on VB-ID capture
- rx_vblank  out  1  rx_vbid[0]
- rx_line_start  out  1  pulse on BE accepted
- rx_line_end  out  1  pulse on BS/SR leaving ACTIVE/STUFF
- rx_err_align  out  1  pulse: active lanes disagree on control flag or code
- rx_err_partial  out  1  pulse: BS/SR arrived with incomplete pixel (byte index != 0)

Behaviour:
- Reset: all outputs 0, FSM = IDLE, byte index 0, header counter 0.
- All outputs are registered. Latency is one cycle from sampling the deciding symbol to the output.
- Active lanes are lanes 0..N-1. Decisions use lane 0's flag/code.
- Alignment check on every cycle:
  - If any active lane's flag differs from lane 0's, or any active lane's control code differs from lane 0's, pulse rx_err_align.
  - That cycle is then ignored: no state change, no byte capture.
- FSM states: IDLE, HUNT, BLANK_HDR, BLANK, ACTIVE, STUFF.
  - IDLE: rx_en=1 -> HUNT.
  - HUNT: BS/SR -> BLANK_HDR, header counter loaded with 12/6/3 for N=1/2/4. Everything else ignored.
  - BLANK_HDR:
    - First data cycle: capture lane 0 into rx_vbid, pulse rx_vbid_vld.
    - Each data cycle decrements the counter; at 0 -> BLANK.
    - Control symbol here -> HUNT, no pulses.
  - BLANK: BE -> ACTIVE, pulse rx_line_start, byte index := 0. BS/SR -> BLANK_HDR. Data is ignored.
  - ACTIVE:
    - Data cycle: store lane bytes at the current byte index (0=R, 1=G, 2=B) and increment the index mod 3.
    - On the B byte: pulse rx_pixel_vld next cycle, rx_pixel_num = N; unused slots are 0.
    - FS -> STUFF, byte index preserved.
    - BS/SR -> BLANK_HDR and pulse rx_line_end; also pulse rx_err_partial if byte index != 0; byte index := 0.
    - BE is ignored.
  - STUFF: all data is discarded. FE -> ACTIVE. BS/SR is handled as in ACTIVE.
- rx_en low in any state:
  - IDLE next cycle, byte index and header counter cleared.
  - rx_vbid is held; pulse outputs are 0.
- Simultaneous B-byte completion and error: impossible, because control and data are exclusive per cycle.
- Header counter and byte index saturate/wrap only as specified.
- rx_pixel_data holds its last value when rx_pixel_vld=0.

Test Plan:
- 4 lanes; BS, VB-ID=8'h01, 2 header, BE, then per lane R/G/B = {10+L, 20+L, 30+L} -> one rx_pixel_vld, rx_pixel_num=4, slot0=24'h0A141E, slot3=24'h0D1721; rx_vblank=1, rx_vbid_vld one cycle after VB-ID.
- 1 lane; BS plus 12 header symbols, BE, 6 data bytes, BS -> two pixel pulses (num=1), rx_line_start then rx_line_end, no errors.
- 2 lanes; BE, R, G, FS, 3 data, FE, B -> stuffing skipped; one pixel pulse, num=2, correct bytes.
- 4 lanes; lane 2 flag=0 while others send BE -> rx_err_align pulse, state remains BLANK; next aligned BE -> rx_line_start.
- 4 lanes; ACTIVE with R,G then SR -> rx_line_end and rx_err_partial together, no pixel pulse, then BLANK_HDR.
- rx_en dropped mid-ACTIVE after R -> IDLE, no pulses. Re-enable, then BS -> HUNT->BLANK_HDR and a fresh VB-ID capture.
